pipe_sched: RTL and testbench

//   Round-robin scheduler sharing one 3-stage (a+b+c-d)*d pipeline among NREQ requesters.

---
 rtl/pipe_sched.sv | 134 +++++++++++++
 tb/tb_pipe_sched.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_sched.sv
// pipe_sched: round-robin, credit-gated issue into a shared 3-stage pipeline with an in-order result FIFO.
// Optional PIPE_SCHED_PERF_EN adds saturating issue/stall counters.
module pipe_sched #(
    parameter int NREQ       = 4,
    parameter int LAT        = 3,
    parameter int FIFO_DEPTH = 4,
    localparam int TAG_W     = $clog2(NREQ)
) (
    input  logic                clk1,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ*5-1:0]   op_a,
    input  logic [NREQ*5-1:0]   op_b,
    input  logic [NREQ*5-1:0]   op_c,
    input  logic [NREQ*5-1:0]   op_d,
    output logic [NREQ-1:0]     gnt,
    output logic [4:0]          pipe_a,
    output logic [4:0]          pipe_b,
    output logic [4:0]          pipe_c,
    output logic [4:0]          pipe_d,
    input  logic [11:0]         f_in,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [TAG_W-1:0]    rsp_tag,
    output logic [11:0]         rsp_data,
    output logic                busy
`ifdef PIPE_SCHED_PERF_EN
    ,
    output logic [15:0]         perf_issued,
    output logic [15:0]         perf_stall
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [TAG_W-1:0]    r_ptr;
    logic [LAT-1:0]      r_vld;
    logic [TAG_W-1:0]    r_tag [LAT];
    logic [TAG_W+11:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wr;
    logic [AW-1:0]       r_rd;
    logic [CW-1:0]       r_cnt;
    logic                w_hit;
    logic [TAG_W-1:0]    w_sel;
    int                  w_inflight;
    logic                w_credit;
    logic                w_issue;
    logic                w_push;
    logic                w_pop;

    // scan downward so the smallest offset from r_ptr wins
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(r_ptr) + k) % NREQ]) begin
                w_hit = 1'b1;
                w_sel = TAG_W'((int'(r_ptr) + k) % NREQ);
            end
        end
    end

    always_comb begin
        w_inflight = 0;
        for (int k = 0; k < LAT; k++)
            w_inflight = w_inflight + int'(r_vld[k]);
    end

    assign w_credit  = (w_inflight + int'(r_cnt)) < FIFO_DEPTH;
    assign w_issue   = w_hit && w_credit;
    assign w_push    = r_vld[LAT-1];
    assign rsp_valid = r_cnt != '0;
    assign w_pop     = rsp_valid && rsp_ready;
    assign busy      = (|r_vld) || rsp_valid;
    assign rsp_tag   = rsp_valid ? r_mem[r_rd][TAG_W+11:12] : '0;
    assign rsp_data  = rsp_valid ? r_mem[r_rd][11:0] : '0;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            gnt    <= '0;
            r_ptr  <= '0;
            pipe_a <= '0;
            pipe_b <= '0;
            pipe_c <= '0;
            pipe_d <= '0;
            r_vld  <= '0;
            for (int k = 0; k < LAT; k++)
                r_tag[k] <= '0;
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
        end else begin
            gnt <= w_issue ? NREQ'(1) << w_sel : '0;
            if (w_issue) begin
                r_ptr  <= TAG_W'((int'(w_sel) + 1) % NREQ);
                pipe_a <= op_a[5*int'(w_sel) +: 5];
                pipe_b <= op_b[5*int'(w_sel) +: 5];
                pipe_c <= op_c[5*int'(w_sel) +: 5];
                pipe_d <= op_d[5*int'(w_sel) +: 5];
            end
            r_vld[0] <= w_issue;
            r_tag[0] <= w_sel;
            for (int k = 1; k < LAT; k++) begin
                r_vld[k] <= r_vld[k-1];
                r_tag[k] <= r_tag[k-1];
            end
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop)
                r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
        end
    end

    // storage needs no reset: head outputs are masked while empty
    always_ff @(posedge clk1) begin
        if (rst_n && w_push)
            r_mem[r_wr] <= {r_tag[LAT-1], f_in};
    end

`ifdef PIPE_SCHED_PERF_EN
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            perf_issued <= '0;
            perf_stall  <= '0;
        end else begin
            if (w_issue && perf_issued != 16'hFFFF)
                perf_issued <= perf_issued + 1'b1;
            if ((|req) && !w_credit && perf_stall != 16'hFFFF)
                perf_stall <= perf_stall + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: directed bench with a grant-to-response scoreboard and a behavioural 3-stage pipeline.
module tb_pipe_sched;
    logic        clk1 = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  req = '0;
    logic [19:0] op_a, op_b, op_c, op_d;
    logic [3:0]  gnt;
    logic [4:0]  pipe_a, pipe_b, pipe_c, pipe_d;
    logic [11:0] f_in, p1, p2;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [1:0]  rsp_tag;
    logic [11:0] rsp_data;
    logic        busy;
`ifdef PIPE_SCHED_PERF_EN
    logic [15:0] perf_issued, perf_stall;
    logic [15:0] base_iss, base_stall;
`endif

    logic [4:0] va [4] = '{5'd3, 5'd31, 5'd5, 5'd17};
    logic [4:0] vb [4] = '{5'd4, 5'd31, 5'd6, 5'd20};
    logic [4:0] vc [4] = '{5'd10, 5'd0, 5'd1, 5'd30};
    logic [4:0] vd [4] = '{5'd2, 5'd31, 5'd9, 5'd7};

    int nchk = 0;
    int npass = 0;
    logic [13:0] sb [$];

    always #5 clk1 = ~clk1;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            op_a[5*i +: 5] = va[i];
            op_b[5*i +: 5] = vb[i];
            op_c[5*i +: 5] = vc[i];
            op_d[5*i +: 5] = vd[i];
        end
    end

    function automatic logic [11:0] ref_f(input logic [4:0] a, b, c, d);
        int s;
        s = ((int'(a) + int'(b)) + ((int'(c) - int'(d)) & 63)) & 127;
        return 12'(s * int'(d));
    endfunction

    // pipeline model: result of the operands launched at edge T is on f_in at edge T+3
    always_ff @(posedge clk1) begin
        p1 <= ref_f(pipe_a, pipe_b, pipe_c, pipe_d);
        p2 <= p1;
    end
    assign f_in = p2;

    pipe_sched dut (
        .clk1(clk1), .rst_n(rst_n), .req(req),
        .op_a(op_a), .op_b(op_b), .op_c(op_c), .op_d(op_d),
        .gnt(gnt), .pipe_a(pipe_a), .pipe_b(pipe_b), .pipe_c(pipe_c), .pipe_d(pipe_d),
        .f_in(f_in), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_tag(rsp_tag), .rsp_data(rsp_data), .busy(busy)
`ifdef PIPE_SCHED_PERF_EN
        , .perf_issued(perf_issued), .perf_stall(perf_stall)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // scoreboard: grants push the expected response, accepted heads pop and compare
    always @(negedge clk1) begin
        if (rst_n) begin
            if (gnt != 4'b0) begin
                chk("gnt_onehot", 32'($onehot(gnt)), 1);
                for (int i = 0; i < 4; i++) begin
                    if (gnt[i]) begin
                        chk("pipe_ops", {pipe_a, pipe_b, pipe_c, pipe_d}, {va[i], vb[i], vc[i], vd[i]});
                        sb.push_back({2'(i), ref_f(va[i], vb[i], vc[i], vd[i])});
                    end
                end
            end
            if (rsp_valid && rsp_ready) begin
                chk("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk("rsp_tag", rsp_tag, sb[0][13:12]);
                    chk("rsp_data", rsp_data, sb[0][11:0]);
                    void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic wait_gnt(input logic [3:0] exp, input string tag, output int n);
        n = 0;
        step();
        while (gnt == 4'b0 && n < 20) begin
            step();
            n++;
        end
        chk(tag, gnt, exp);
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (busy && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_idle"}, busy, 0);
        chk({tag, "_sb_empty"}, sb.size(), 0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"}, gnt, 0);
        chk({tag, "_pipe"}, {pipe_a, pipe_b, pipe_c, pipe_d}, 0);
        chk({tag, "_valid"}, rsp_valid, 0);
        chk({tag, "_tag"}, rsp_tag, 0);
        chk({tag, "_data"}, rsp_data, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        int n, ng, seen;
        int order [5] = '{1, 2, 3, 0, 1};
        repeat (2) @(posedge clk1);
        #1;
        chk_zero("reset");
        rst_n = 1'b1;
        step();

        // single op, fixed latency and known result
        rsp_ready = 1'b1;
        req = 4'b0001;
        step();
        chk("s1_gnt", gnt, 4'b0001);
        req = 4'b0000;
        step();
        chk("s1_pulse", gnt, 0);
        chk("s1_lat1", rsp_valid, 0);
        step();
        chk("s1_lat2", rsp_valid, 0);
        step();
        chk("s1_valid", rsp_valid, 1);
        chk("s1_tag", rsp_tag, 0);
        chk("s1_data", rsp_data, 30);
        step();
        chk("s1_done", busy, 0);

        // all requesting; the fifth grant waits one bubble on credits
        req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            wait_gnt(4'b0001 << order[g], "s2_order", n);
            if (g > 0)
                chk("s2_spacing", n, g == 4 ? 1 : 0);
        end
        req = 4'b0000;
        drain("s2");

        // stalled consumer: credits cap issue at FIFO depth
`ifdef PIPE_SCHED_PERF_EN
        base_iss = perf_issued;
        base_stall = perf_stall;
`endif
        rsp_ready = 1'b0;
        req = 4'b1111;
        ng = 0;
        repeat (8) begin
            step();
            if (gnt != 4'b0) ng++;
        end
        chk("s3_grants", ng, 4);
        chk("s3_gnt_idle", gnt, 0);
        chk("s3_busy", busy, 1);
        chk("s3_head_valid", rsp_valid, 1);
        chk("s3_head_tag", rsp_tag, 2);
        chk("s3_head_data", rsp_data, 603);
`ifdef PIPE_SCHED_PERF_EN
        chk("perf_issued", perf_issued - base_iss, 4);
        chk("perf_stall", perf_stall - base_stall, 4);
        step();
        chk("perf_stall_inc", perf_stall - base_stall, 5);
`endif
        rsp_ready = 1'b1;
        ng = 0;
        repeat (10) begin
            step();
            if (gnt != 4'b0) ng++;
        end
        chk("s3_resume", 32'(ng > 0), 1);
        req = 4'b0000;
        drain("s3");

        // pointer wrap from 3 back to 0
        req = 4'b1000;
        wait_gnt(4'b1000, "s4_g3", n);
        req = 4'b1001;
        wait_gnt(4'b0001, "s4_wrap0", n);
        chk("s4_wrap0_now", n, 0);
        req = 4'b1000;
        wait_gnt(4'b1000, "s4_then3", n);
        req = 4'b0000;
        drain("s4");

        // reset with two ops in the shifter and one in the FIFO
        rsp_ready = 1'b0;
        req = 4'b1111;
        repeat (3) step();
        req = 4'b0000;
        step();
        chk("s5_setup_valid", rsp_valid, 1);
        chk("s5_setup_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("s5_async");
        sb.delete();
        repeat (2) @(posedge clk1);
        #1;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 0;
        repeat (8) begin
            step();
            seen = seen | int'(rsp_valid) | int'(busy);
        end
        chk("s5_no_stale", seen, 0);
        chk("final_sb_empty", sb.size(), 0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
